perf_counter_readout: RTL and testbench

Reader side of the performance event counter block. On a trigger it snapshots the flattened counter array and clears the live counters in the same cycle. It then streams the snapshot out one counter per beat over an AXI-Stream-style master interface towards the host/DMA path. Sits directly downstream of performance_event_counters.

---
 rtl/perf_readout_pkg.sv | 25 ++
 rtl/perf_counter_readout.sv | 113 +++++++++++
 tb/tb_perf_counter_readout.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/perf_readout_pkg.sv
// Shared types and constants for the perf counter readout block.
// The HEADER state only exists when PERF_READOUT_HEADER_EN is defined.
package perf_readout_pkg;

`ifdef PERF_READOUT_HEADER_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        STREAM = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd2
    } state_e;
`endif

    localparam int unsigned HDR_NUM_LSB = 0;
    localparam int unsigned HDR_NUM_W   = 16;
    localparam int unsigned HDR_SEQ_LSB = 16;
    localparam int unsigned HDR_SEQ_W   = 16;

    localparam logic [7:0] DROP_SAT = 8'hFF;

endpackage

// File: rtl/perf_counter_readout.sv
// Snapshots and clears the live event counters on trigger, then streams the snapshot
// one counter per beat. Define PERF_READOUT_HEADER_EN to prepend a count/sequence header beat.
module perf_counter_readout
    import perf_readout_pkg::*;
#(
    parameter int unsigned NUM_COUNTERS  = 115,
    parameter int unsigned COUNTER_WIDTH = 7,
    parameter int unsigned DATA_WIDTH    = 64
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] counters_flat,
    input  logic                                  trigger,
    output logic                                  counters_clear,
    output logic [DATA_WIDTH-1:0]                 m_tdata,
    output logic                                  m_tvalid,
    input  logic                                  m_tready,
    output logic                                  m_tlast,
    output logic                                  busy,
    output logic [7:0]                            dropped_triggers
);

    localparam int unsigned IDX_W = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COUNTERS - 1);

    state_e                                state_q, state_d;
    logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] snap_q, snap_d;
    logic [IDX_W-1:0]                      idx_q, idx_d;
    logic [7:0]                            drop_q, drop_d;
`ifdef PERF_READOUT_HEADER_EN
    logic [15:0]                           seq_q, seq_d;
    logic [15:0]                           hdr_seq_q, hdr_seq_d;
`endif

    always_comb begin
        state_d        = state_q;
        snap_d         = snap_q;
        idx_d          = idx_q;
        drop_d         = drop_q;
`ifdef PERF_READOUT_HEADER_EN
        seq_d          = seq_q;
        hdr_seq_d      = hdr_seq_q;
`endif
        counters_clear = 1'b0;
        m_tvalid       = 1'b0;
        m_tlast        = 1'b0;
        m_tdata        = '0;

        unique case (state_q)
            IDLE: begin
                counters_clear = trigger;
                if (trigger) begin
                    snap_d = counters_flat;
                    idx_d  = '0;
`ifdef PERF_READOUT_HEADER_EN
                    // Header shows the pre-increment number, so the first frame is 0.
                    hdr_seq_d = seq_q;
                    seq_d     = seq_q + 16'd1;
                    state_d   = HEADER;
`else
                    state_d   = STREAM;
`endif
                end
            end
`ifdef PERF_READOUT_HEADER_EN
            HEADER: begin
                m_tvalid = 1'b1;
                m_tdata[HDR_NUM_LSB +: HDR_NUM_W] = HDR_NUM_W'(NUM_COUNTERS);
                m_tdata[HDR_SEQ_LSB +: HDR_SEQ_W] = hdr_seq_q;
                if (m_tready) state_d = STREAM;
            end
`endif
            STREAM: begin
                m_tvalid = 1'b1;
                m_tdata  = DATA_WIDTH'(snap_q[int'(idx_q) * COUNTER_WIDTH +: COUNTER_WIDTH]);
                m_tlast  = (idx_q == LAST_IDX);
                if (m_tready) begin
                    if (idx_q == LAST_IDX) state_d = IDLE;
                    else                   idx_d   = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (trigger && (state_q != IDLE) && (drop_q != DROP_SAT)) drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            idx_q     <= '0;
            drop_q    <= '0;
`ifdef PERF_READOUT_HEADER_EN
            seq_q     <= '0;
            hdr_seq_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            idx_q     <= idx_d;
            drop_q    <= drop_d;
`ifdef PERF_READOUT_HEADER_EN
            seq_q     <= seq_d;
            hdr_seq_q <= hdr_seq_d;
`endif
        end
    end

    assign busy             = (state_q != IDLE);
    assign dropped_triggers = drop_q;

endmodule

// File: tb/tb_perf_counter_readout.sv
// Self-checking bench for perf_counter_readout with a frame-level reference model.
module tb_perf_counter_readout;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 7;
    localparam int unsigned DW = 64;
`ifdef PERF_READOUT_HEADER_EN
    localparam int unsigned FRAME = N + 1;
`else
    localparam int unsigned FRAME = N;
`endif
    localparam int unsigned VW = 12 + DW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N*CW-1:0]   counters_flat = '0;
    logic              trigger = 1'b0;
    logic              counters_clear;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tready = 1'b0;
    logic              m_tlast;
    logic              busy;
    logic [7:0]        dropped_triggers;

    perf_counter_readout #(
        .NUM_COUNTERS  (N),
        .COUNTER_WIDTH (CW),
        .DATA_WIDTH    (DW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .counters_flat    (counters_flat),
        .trigger          (trigger),
        .counters_clear   (counters_clear),
        .m_tdata          (m_tdata),
        .m_tvalid         (m_tvalid),
        .m_tready         (m_tready),
        .m_tlast          (m_tlast),
        .busy             (busy),
        .dropped_triggers (dropped_triggers)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    // Reference model: a frame is just a list of beats still owed to the sink.
    beat_t       mdl_q[$];
    bit          mdl_busy = 1'b0;
    int unsigned mdl_drop = 0;
    logic [15:0] mdl_seq  = '0;

    int n_cmp = 0;
    int n_err = 0;

    logic [VW-1:0] obs_vec, exp_vec;

    task automatic step(input bit rst, input bit trig, input bit rdy, input logic [N*CW-1:0] flat);
        beat_t b;
        bit    was_busy;
        @(negedge clk);
        rst_n         = !rst;
        trigger       = trig;
        m_tready      = rdy;
        counters_flat = flat;
        #1;
        b = mdl_busy ? mdl_q[0] : '0;
        exp_vec = {mdl_busy, mdl_busy, b.last, trig && !mdl_busy, 8'(mdl_drop), b.data};
        obs_vec = {m_tvalid, busy, m_tlast, counters_clear, dropped_triggers, m_tdata};
        if (rst) begin
            mdl_q.delete();
            mdl_busy = 1'b0;
            mdl_drop = 0;
            mdl_seq  = '0;
        end else begin
            was_busy = mdl_busy;
            if (mdl_busy && rdy) begin
                void'(mdl_q.pop_front());
                if (mdl_q.size() == 0) mdl_busy = 1'b0;
            end
            if (trig) begin
                if (!was_busy) begin
`ifdef PERF_READOUT_HEADER_EN
                    mdl_q.push_back('{data: DW'({mdl_seq, 16'(N)}), last: 1'b0});
                    mdl_seq = mdl_seq + 16'd1;
`endif
                    for (int k = 0; k < int'(N); k++)
                        mdl_q.push_back('{data: DW'(flat[k*CW +: CW]), last: (k == int'(N) - 1)});
                    mdl_busy = 1'b1;
                end else if (mdl_drop < 255) begin
                    mdl_drop++;
                end
            end
        end
    endtask

    function automatic logic [N*CW-1:0] rnd_flat();
        logic [N*CW-1:0] f;
        for (int k = 0; k < int'(N); k++) f[k*CW +: CW] = CW'($urandom);
        return f;
    endfunction

    task automatic test_reset();
        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        n_cmp++;
        if (obs_vec !== exp_vec) begin
            n_err++;
            $display("FAIL reset got=%h want=%h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_full_rate();
        logic [N*CW-1:0] flat;
        int busy_cnt, clr_cnt;
        flat = {7'd9, 7'd3, 7'd0, 7'd127};
        busy_cnt = 0;
        clr_cnt  = 0;
        for (int c = 0; c < int'(FRAME) + 3; c++) begin
            step(0, c == 0, 1, flat);
            busy_cnt += int'(busy);
            clr_cnt  += int'(counters_clear);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL full_rate cyc%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
        end
        n_cmp++;
        if (busy_cnt != int'(FRAME) || clr_cnt != 1) begin
            n_err++;
            $display("FAIL full_rate_len busy=%0d clr=%0d want busy=%0d clr=1", busy_cnt, clr_cnt, FRAME);
        end
    endtask

    task automatic test_stall_toggle();
        int busy_cnt;
        busy_cnt = 0;
        step(0, 1, 0, {7'd9, 7'd3, 7'd0, 7'd127});
        for (int c = 1; c < 2 * int'(FRAME) + 4; c++) begin
            // counters_flat changes every cycle: the snapshot must not follow it
            step(0, 0, (c % 2) == 0, rnd_flat());
            busy_cnt += int'(busy);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL stall_toggle cyc%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
        end
        n_cmp++;
        if (busy_cnt != 2 * int'(FRAME)) begin
            n_err++;
            $display("FAIL stall_len busy=%0d want=%0d", busy_cnt, 2 * FRAME);
        end
    endtask

    task automatic test_trigger_held();
        int clr_cnt;
        clr_cnt = 0;
        for (int c = 0; c < 10 + int'(FRAME) + 2; c++) begin
            step(0, c < 10, 1, rnd_flat());
            clr_cnt += int'(counters_clear);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL trig_held cyc%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
        end
        n_cmp++;
        if (clr_cnt != 2) begin
            n_err++;
            $display("FAIL trig_held_clear count=%0d want=2", clr_cnt);
        end
    endtask

    task automatic test_saturate();
        for (int c = 0; c < 300; c++) begin
            step(0, 1, 0, rnd_flat());
            if (c % 50 == 0 || c == 299) begin
                n_cmp++;
                if (obs_vec !== exp_vec) begin
                    n_err++;
                    $display("FAIL saturate cyc%0d got=%h want=%h", c, obs_vec, exp_vec);
                end
            end
        end
        step(0, 0, 0, '0);
        n_cmp++;
        if (dropped_triggers !== 8'd255) begin
            n_err++;
            $display("FAIL saturate_value got=%0d want=255", dropped_triggers);
        end
        for (int c = 0; c < int'(FRAME) + 2; c++) begin
            step(0, 0, 1, rnd_flat());
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL saturate_drain cyc%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(0, 1, 1, rnd_flat());
        step(0, 0, 1, rnd_flat());
        step(0, 0, 1, rnd_flat());
        step(1, 0, 0, rnd_flat());
        n_cmp++;
        if (obs_vec !== exp_vec) begin
            n_err++;
            $display("FAIL reset_mid_pre got=%h want=%h", obs_vec, exp_vec);
        end
        for (int c = 0; c < int'(FRAME) + 4; c++) begin
            step(0, c == 1, 1, {7'd11, 7'd22, 7'd33, 7'd44});
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL reset_mid cyc%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 400; c++) begin
            step(0, ($urandom % 4) == 0, ($urandom % 3) != 0, rnd_flat());
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL random cyc%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
        end
        for (int c = 0; c < 2 * int'(FRAME) + 2; c++) begin
            step(0, 0, 1, '0);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL random_drain cyc%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
        end
    endtask

`ifdef PERF_READOUT_HEADER_EN
    task automatic test_header();
        logic [DW-1:0] first [2];
        int fr;
        bit prev_valid;
        step(1, 0, 0, '0);
        fr = 0;
        prev_valid = 1'b0;
        for (int c = 0; c < 2 * int'(FRAME) + 4; c++) begin
            step(0, c == 0 || c == int'(FRAME) + 1, 1, rnd_flat());
            if (m_tvalid && !prev_valid && fr < 2) begin
                first[fr] = m_tdata;
                fr++;
            end
            prev_valid = m_tvalid;
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL header cyc%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
        end
        n_cmp++;
        if (fr != 2 || first[0] !== 64'h0000_0004 || first[1] !== 64'h0001_0004) begin
            n_err++;
            $display("FAIL header_words frames=%0d got=%h,%h want=2 frames 4,10004", fr, first[0], first[1]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_rate();
        test_stall_toggle();
        test_trigger_held();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
`ifdef PERF_READOUT_HEADER_EN
        test_header();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
